// File: rtl/as512_pkg.sv
// Shared types and constants for the as512 bus responder.
// Holds the FSM state encoding and bus-level constants.
package as512_pkg;

  localparam int BUS_W = 16;
  localparam logic [BUS_W-1:0] TIMEOUT_DATA = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WREQ,
    ST_RREQ,
    ST_RHOLD
  } state_t;

endpackage

// File: rtl/as512_bus_responder_if.sv
// CPU pin bundle plus req/ack memory port of the responder.
// slave = responder side, master = CPU/memory environment side.
interface as512_bus_responder_if #(
  parameter int ADDR_W = 24
);
  import as512_pkg::*;

  logic [BUS_W-1:0]  bus_in;
  logic [BUS_W-1:0]  bus_out;
  logic              bus_oe;
  logic              len1;
  logic              len2;
  logic              rw;
  logic              opreq;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BUS_W-1:0]  mem_wdata;
  logic [BUS_W-1:0]  mem_rdata;
  logic              mem_ack;
  logic              busy;
  logic              err_timeout;
  logic              err_overrun;

  modport slave (
    input  bus_in, len1, len2, rw, opreq,
    input  mem_rdata, mem_ack,
    output bus_out, bus_oe,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output busy, err_timeout, err_overrun
  );

  modport master (
    output bus_in, len1, len2, rw, opreq,
    output mem_rdata, mem_ack,
    input  bus_out, bus_oe,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  busy, err_timeout, err_overrun
  );

endinterface

// File: rtl/as512_wait_timer.sv
// Loadable down-counter used to bound the wait for mem_ack.
// o_expired is high while running with the count exhausted.
module as512_wait_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_run,
  input  logic [W-1:0] i_load_val,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  // Load on request start, count down while the request is open
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_expired = i_run && (r_cnt == '0);

endmodule

// File: rtl/as512_bus_responder.sv
// Target side of the as512 external bus.
// Turns CPU address/op strobes into req/ack memory requests.
module as512_bus_responder
  import as512_pkg::*;
#(
  parameter int ADDR_W   = 24,
  parameter int MAX_WAIT = 15,
  parameter int AUTO_INC = 1
) (
  input logic                 clk,
  input logic                 rst,
  as512_bus_responder_if.slave bus
);

  // ADDR_W is expected in 17..32: len2 supplies the upper bits.
  localparam int CW = $clog2(MAX_WAIT + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [BUS_W-1:0]  r_wdata;
  logic [BUS_W-1:0]  r_rdout;
  logic              r_err_to;
  logic              r_err_ov;
  logic              w_busy;
  logic              w_start;
  logic              w_expired;
  logic              w_ack_done;
  logic              w_timeout;
  logic              w_len;

  assign w_busy     = (r_state == ST_WREQ) || (r_state == ST_RREQ);
  assign w_len      = bus.len1 || bus.len2;
  assign w_start    = !w_busy && bus.opreq;
  assign w_ack_done = w_busy && bus.mem_ack;
  assign w_timeout  = w_expired && !bus.mem_ack;

  as512_wait_timer #(
    .W (CW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_start),
    .i_run      (w_busy),
    .i_load_val (CW'(MAX_WAIT - 1)),
    .o_expired  (w_expired)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: RHOLD behaves like IDLE once the CPU acts again
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE, ST_RHOLD: begin
        if (bus.opreq)
          w_state_nxt = bus.rw ? ST_WREQ : ST_RREQ;
        else if (w_len)
          w_state_nxt = ST_IDLE;
      end
      ST_WREQ: begin
        if (w_ack_done || w_timeout) w_state_nxt = ST_IDLE;
      end
      ST_RREQ: begin
        if (w_ack_done)     w_state_nxt = ST_RHOLD;
        else if (w_timeout) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Address merge from the two latch enables
  always_comb begin
    w_addr_nxt = r_addr;
    if (bus.len1) w_addr_nxt[15:0] = bus.bus_in;
    if (bus.len2) w_addr_nxt[ADDR_W-1:16] = bus.bus_in[ADDR_W-17:0];
  end

  // Address, write data, read data and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdout  <= '0;
      r_err_to <= 1'b0;
      r_err_ov <= 1'b0;
    end else begin
      if (w_busy) begin
        if (w_len || bus.opreq) r_err_ov <= 1'b1;
        if ((w_ack_done || w_timeout) && (AUTO_INC != 0))
          r_addr <= r_addr + ADDR_W'(1);
      end else begin
        if (w_len) r_addr <= w_addr_nxt;
        if (bus.opreq && bus.rw) r_wdata <= bus.bus_in;
      end
      if (w_timeout) r_err_to <= 1'b1;
      if (r_state == ST_RREQ) begin
        if (bus.mem_ack)    r_rdout <= bus.mem_rdata;
        else if (w_timeout) r_rdout <= TIMEOUT_DATA;
      end
    end
  end

  assign bus.mem_req     = w_busy;
  assign bus.mem_we      = (r_state == ST_WREQ);
  assign bus.mem_addr    = r_addr;
  assign bus.mem_wdata   = r_wdata;
  assign bus.bus_out     = r_rdout;
  assign bus.bus_oe      = (r_state == ST_RHOLD) && !bus.rw && !w_len;
  assign bus.busy        = w_busy;
  assign bus.err_timeout = r_err_to;
  assign bus.err_overrun = r_err_ov;

endmodule
